// File: rtl/pll_lock_reset_sequencer_if.sv
// rtl/pll_lock_reset_sequencer_if.sv - signal bundle between the PLL sequencer and the clocking subsystem
//
// Signals:
//   pll_locked  asynchronous lock indicators from the PLL(s)
//   pll_rst     shared PLL reset, active-high
//   chan_rst    per-domain resets, active-high
//   all_ready   high while every domain is out of reset
//   lock_lost   sticky flag: lock dropped while running
//   retry_cnt   failed bring-up attempts since the last entry to run
//   error       retries exhausted; sequencer parked with everything in reset
// Modports:
//   master  sequencer side (drives resets and status, reads pll_locked)
//   slave   consumer side (drives pll_locked, reads resets and status)
interface pll_lock_reset_sequencer_if #(
    parameter int NUM_PLL     = 1,
    parameter int NUM_CH      = 4,
    parameter int MAX_RETRIES = 3,
    parameter int RW          = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
);
    logic [NUM_PLL-1:0] pll_locked;
    logic               pll_rst;
    logic [NUM_CH-1:0]  chan_rst;
    logic               all_ready;
    logic               lock_lost;
    logic [RW-1:0]      retry_cnt;
    logic               error;

    modport master (
        input  pll_locked,
        output pll_rst, chan_rst, all_ready, lock_lost, retry_cnt, error
    );

    modport slave (
        output pll_locked,
        input  pll_rst, chan_rst, all_ready, lock_lost, retry_cnt, error
    );
endinterface

// File: rtl/pll_lock_reset_sequencer.sv
// rtl/pll_lock_reset_sequencer.sv - PLL reset, lock qualification and staggered domain reset release
//
// Ports:
//   refclk  free-running reference clock, the only clock of the block
//   rst     asynchronous active-high reset
//   bus     pll_lock_reset_sequencer_if.master: pll_locked in; pll_rst, chan_rst,
//           all_ready, lock_lost, retry_cnt, error out (all outputs registered)
module pll_lock_reset_sequencer #(
    parameter int NUM_PLL        = 1,
    parameter int NUM_CH         = 4,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 1024,
    parameter int STABLE_CYCLES  = 64,
    parameter int STAGGER        = 8,
    parameter int MAX_RETRIES    = 3,
    parameter int SYNC_STAGES    = 2
) (
    input logic                        refclk,
    input logic                        rst,
    pll_lock_reset_sequencer_if.master bus
);
    localparam int RW       = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int REL_LAST = STAGGER * (NUM_CH - 1);
    localparam int MAX_A    = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B    = (STABLE_CYCLES > REL_LAST) ? STABLE_CYCLES : REL_LAST;
    localparam int CNT_MAX  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW       = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] PLL_RST_TC  = CW'(PLL_RST_CYCLES);
    localparam logic [CW-1:0] LOCK_TC     = CW'(LOCK_TIMEOUT);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] REL_TC      = CW'(REL_LAST);
    localparam logic [CW-1:0] CNT_SAT     = CW'(CNT_MAX);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RELEASE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t                              state_q, state_d;
    logic [CW-1:0]                       cnt_q, cnt_d;
    logic [RW-1:0]                       retry_q, retry_d;
    logic [SYNC_STAGES-1:0][NUM_PLL-1:0] sync_q, sync_d;
    logic                                pll_rst_q, pll_rst_d;
    logic [NUM_CH-1:0]                   chan_rst_q, chan_rst_d;
    logic                                all_ready_q, all_ready_d;
    logic                                lock_lost_q, lock_lost_d;
    logic                                error_q, error_d;
    logic                                fail_attempt;
    logic                                lk;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == CNT_SAT) ? c : c + CW'(1);
    endfunction

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
    end

    assign lk = &sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        retry_d      = retry_q;
        lock_lost_d  = lock_lost_q;
        fail_attempt = 1'b0;

        // Counters restart at 1 when the entry cycle itself counts toward the
        // terminal value, and at 0 when counting starts on the following cycle.
        case (state_q)
            S_RESET_PLL: begin
                if (cnt_q >= PLL_RST_TC) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            S_WAIT_LOCK: begin
                if (lk) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q >= LOCK_TC) begin
                    fail_attempt = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            S_STABLE: begin
                if (!lk) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = CW'(1);
                end else if (cnt_q >= STABLE_LAST) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            S_RELEASE: begin
                if (!lk) begin
                    fail_attempt = 1'b1;
                end else if (cnt_q >= REL_TC) begin
                    state_d = S_RUN;
                    retry_d = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            S_RUN: begin
                if (!lk) begin
                    state_d     = S_RESET_PLL;
                    cnt_d       = CW'(1);
                    lock_lost_d = 1'b1;
                end
            end
            S_FAIL: begin
            end
            default: begin
                state_d = S_RESET_PLL;
                cnt_d   = CW'(1);
            end
        endcase

        if (fail_attempt) begin
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + RW'(1);
                state_d = S_RESET_PLL;
                cnt_d   = CW'(1);
            end else begin
                state_d = S_FAIL;
            end
        end

        // Outputs are decoded from the next state so they change on the same
        // edge as the state transition.
        pll_rst_d   = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
        all_ready_d = (state_d == S_RUN);
        error_d     = (state_d == S_FAIL);
        for (int k = 0; k < NUM_CH; k++) begin
            chan_rst_d[k] = !((state_d == S_RUN) ||
                              ((state_d == S_RELEASE) && (int'(cnt_d) >= k * STAGGER)));
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= S_RESET_PLL;
            cnt_q       <= '0;
            retry_q     <= '0;
            sync_q      <= '0;
            pll_rst_q   <= 1'b1;
            chan_rst_q  <= '1;
            all_ready_q <= 1'b0;
            lock_lost_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            sync_q      <= sync_d;
            pll_rst_q   <= pll_rst_d;
            chan_rst_q  <= chan_rst_d;
            all_ready_q <= all_ready_d;
            lock_lost_q <= lock_lost_d;
            error_q     <= error_d;
        end
    end

    assign bus.pll_rst   = pll_rst_q;
    assign bus.chan_rst  = chan_rst_q;
    assign bus.all_ready = all_ready_q;
    assign bus.lock_lost = lock_lost_q;
    assign bus.retry_cnt = retry_q;
    assign bus.error     = error_q;
endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
// tb/tb_pll_lock_reset_sequencer.sv - scoreboard bench for pll_lock_reset_sequencer
module tb_pll_lock_reset_sequencer;
    localparam int NUM_PLL = 2;
    localparam int NUM_CH  = 3;
    localparam int MAX_RET = 1;

    typedef struct {
        int         cyc;
        logic [7:0] vec;
        string      name;
    } exp_t;

    logic       refclk = 1'b0;
    logic       rst    = 1'b1;
    int         cyc    = 0;
    int         checks = 0;
    int         failures = 0;
    exp_t       exp_q[$];
    logic [7:0] prev_vec = 8'hF0;
    logic       prev_rst = 1'b0;

    pll_lock_reset_sequencer_if #(
        .NUM_PLL    (NUM_PLL),
        .NUM_CH     (NUM_CH),
        .MAX_RETRIES(MAX_RET)
    ) bus ();

    pll_lock_reset_sequencer #(
        .NUM_PLL       (NUM_PLL),
        .NUM_CH        (NUM_CH),
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .STAGGER       (2),
        .MAX_RETRIES   (MAX_RET),
        .SYNC_STAGES   (2)
    ) dut (
        .refclk(refclk),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 refclk = ~refclk;

    // Cycle index: 0 while in reset, k after the k-th edge following release.
    always @(posedge refclk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Output vector: {pll_rst, chan_rst[2:0], all_ready, lock_lost, retry_cnt, error}
    function automatic logic [7:0] mk(input logic p, input logic [2:0] c, input logic a,
                                      input logic l, input logic r, input logic e);
        return {p, c, a, l, r, e};
    endfunction

    task automatic push(input int c, input logic [7:0] v, input string n);
        exp_t e;
        e.cyc  = c;
        e.vec  = v;
        e.name = n;
        exp_q.push_back(e);
    endtask

    // Monitor: every change of the output vector, and every entry into reset,
    // is an output event that must match the next queued expectation.
    always @(negedge refclk) begin
        logic [7:0] v;
        exp_t       e;
        v = {bus.pll_rst, bus.chan_rst, bus.all_ready, bus.lock_lost, bus.retry_cnt, bus.error};
        if ((v !== prev_vec) || (rst && !prev_rst)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event: got cyc=%0d out=%b required no event", cyc, v);
            end else begin
                e = exp_q.pop_front();
                if ((v !== e.vec) || (cyc != e.cyc)) begin
                    failures++;
                    $display("FAIL %s: got cyc=%0d out=%b required cyc=%0d out=%b",
                             e.name, cyc, v, e.cyc, e.vec);
                end
            end
        end
        prev_vec = v;
        prev_rst = rst;
    end

    task automatic at_cyc(input int n);
        while (cyc < n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic do_reset(input logic [1:0] pins, input string n);
        push(0, mk(1, 3'b111, 0, 0, 0, 0), n);
        @(posedge refclk);
        #1;
        rst = 1'b1;
        bus.pll_locked = pins;
        repeat (3) @(posedge refclk);
        #1;
        rst = 1'b0;
    endtask

    task automatic push_release(input int t, input logic ll, input string n);
        push(t,     mk(0, 3'b110, 0, ll, 0, 0), {n, "_chan0"});
        push(t + 2, mk(0, 3'b100, 0, ll, 0, 0), {n, "_chan1"});
        push(t + 4, mk(0, 3'b000, 0, ll, 0, 0), {n, "_chan2"});
        push(t + 5, mk(0, 3'b000, 1, ll, 0, 0), {n, "_run"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion required summary within time limit");
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.pll_locked = 2'b00;

        // Clean bring-up, then lock loss in RUN and recovery.
        do_reset(2'b00, "a_reset");
        push(5, mk(0, 3'b111, 0, 0, 0, 0), "a_pll_rst_low");
        push_release(21, 1'b0, "a");
        at_cyc(10);
        bus.pll_locked = 2'b11;
        push(33, mk(1, 3'b111, 0, 1, 0, 0), "a_loss_detect");
        push(37, mk(0, 3'b111, 0, 1, 0, 0), "a_loss_pll_rst_low");
        push_release(46, 1'b1, "a_relock");
        at_cyc(30);
        bus.pll_locked = 2'b00;
        at_cyc(33);
        bus.pll_locked = 2'b11;
        at_cyc(60);

        // Single-cycle lock drop while in STABLE restarts the stability window.
        do_reset(2'b00, "b_reset");
        push(5, mk(0, 3'b111, 0, 0, 0, 0), "b_pll_rst_low");
        push_release(27, 1'b0, "b");
        at_cyc(10);
        bus.pll_locked = 2'b11;
        at_cyc(15);
        bus.pll_locked = 2'b00;
        at_cyc(16);
        bus.pll_locked = 2'b11;
        at_cyc(40);

        // Lock never arrives: one retry, then FAIL held until reset.
        do_reset(2'b00, "c_reset");
        push(5,  mk(0, 3'b111, 0, 0, 0, 0), "c_pll_rst_low");
        push(25, mk(1, 3'b111, 0, 0, 1, 0), "c_timeout_retry");
        push(29, mk(0, 3'b111, 0, 0, 1, 0), "c_retry_pll_rst_low");
        push(49, mk(1, 3'b111, 0, 0, 1, 1), "c_fail");
        at_cyc(80);

        // Only one of two PLLs locks on each attempt: same outcome as no lock.
        do_reset(2'b00, "d_reset");
        push(5,  mk(0, 3'b111, 0, 0, 0, 0), "d_pll_rst_low");
        push(25, mk(1, 3'b111, 0, 0, 1, 0), "d_timeout_retry");
        push(29, mk(0, 3'b111, 0, 0, 1, 0), "d_retry_pll_rst_low");
        push(49, mk(1, 3'b111, 0, 0, 1, 1), "d_fail");
        at_cyc(10);
        bus.pll_locked = 2'b01;
        at_cyc(27);
        bus.pll_locked = 2'b10;
        at_cyc(80);

        // Reset asserted between edges during RELEASE, then a full restart.
        do_reset(2'b00, "e_reset");
        push(5,  mk(0, 3'b111, 0, 0, 0, 0), "e_pll_rst_low");
        push(21, mk(0, 3'b110, 0, 0, 0, 0), "e_chan0");
        push(23, mk(0, 3'b100, 0, 0, 0, 0), "e_chan1");
        at_cyc(10);
        bus.pll_locked = 2'b11;
        at_cyc(23);
        do_reset(2'b11, "e_async_reset");
        push(5, mk(0, 3'b111, 0, 0, 0, 0), "e_restart_pll_rst_low");
        push_release(14, 1'b0, "e_restart");
        at_cyc(30);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drained: got %0d pending events (next %s) required 0",
                     exp_q.size(), exp_q[0].name);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pll_lock_reset_sequencer.md
Name: pll_lock_reset_sequencer

Overview:
- Parametrised clock-and-reset manager that sits beside one or more PLL instances in the SoC clocking subsystem.
- Drives a shared PLL reset and synchronises the asynchronous `locked` inputs into the `refclk` domain.
- Releases per-domain resets in a staggered order once lock has been stable for a set time.
- Recovers automatically from lock loss with a bounded retry count; raises a sticky error when retries are exhausted.

Parameters:
- NUM_PLL, 1, number of PLL locked inputs monitored; all must be locked.
- NUM_CH, 4, number of downstream reset outputs.
- PLL_RST_CYCLES, 16, refclk cycles `pll_rst` is held high per reset attempt (>=1).
- LOCK_TIMEOUT, 1024, cycles allowed in WAIT_LOCK before an attempt counts as failed (>=1).
- STABLE_CYCLES, 64, consecutive cycles all synced locks must be high before release (>=1).
- STAGGER, 8, cycles between successive channel reset releases (>=1).
- MAX_RETRIES, 3, failed attempts tolerated before FAIL (>=0).
- SYNC_STAGES, 2, synchroniser depth for `pll_locked` (>=2).

Ports:
- refclk  in  1  free-running reference clock; only clock of the block.
- rst  in  1  asynchronous, active-high reset.
- pll_locked  in  NUM_PLL  asynchronous PLL lock indicators.
- pll_rst  out  1  registered reset to the PLL(s), active-high.
- chan_rst  out  NUM_CH  registered per-domain resets, active-high.
- all_ready  out  1  high only in RUN.
- lock_lost  out  1  sticky: set on lock loss in RUN; cleared only by `rst`.
- retry_cnt  out  clog2(MAX_RETRIES+1)  failed attempts since last RUN entry.
- error  out  1  high in FAIL.

Behaviour:
- Reset values while `rst` is high:
  - pll_rst=1, chan_rst=all 1s, all_ready=0, lock_lost=0, retry_cnt=0, error=0.
  - Synchroniser flops cleared to 0; state = RESET_PLL with counter 0.
- All outputs are registered. Synced lock (`lk`) is the AND of the pll_locked synchroniser outputs, which lag the pins by SYNC_STAGES cycles.
- RESET_PLL:
  - pll_rst=1 for exactly PLL_RST_CYCLES cycles, counted from the first clock edge after `rst` falls, or from state entry.
  - Then go to WAIT_LOCK; pll_rst=0 in the same cycle as entry.
- WAIT_LOCK:
  - The timeout counter counts up each cycle.
  - If `lk`=1, go to STABLE with the stable counter at 0.
  - If the counter reaches LOCK_TIMEOUT with `lk`=0, it is a failed attempt:
    - if retry_cnt < MAX_RETRIES: increment retry_cnt and go to RESET_PLL;
    - else go to FAIL.
- STABLE:
  - The counter increments while `lk`=1.
  - If `lk`=0 in any cycle, return to WAIT_LOCK with a fresh timeout count. This is not a failed attempt.
  - After STABLE_CYCLES consecutive high cycles, go to RELEASE.
- RELEASE:
  - chan_rst[0] clears on the cycle of entry; chan_rst[k] clears STAGGER*k cycles later.
  - After chan_rst[NUM_CH-1] clears, go to RUN next cycle.
  - If `lk`=0 during RELEASE: set all chan_rst=1 the next cycle, go to RESET_PLL. lock_lost is not set; retry_cnt is incremented as a failed attempt, going to FAIL if the limit is already reached.
- RUN:
  - all_ready=1. retry_cnt is cleared on entry.
  - If `lk`=0: next cycle chan_rst=all 1s, all_ready=0, lock_lost=1, go to RESET_PLL. This does not increment retry_cnt.
- FAIL:
  - pll_rst=1, chan_rst=all 1s, error=1. Absorbing state; only `rst` exits.
- Glitch handling: a lock pulse narrower than one refclk period may be missed. A pulse captured by the synchroniser is acted on as above.
- Asserting `rst` mid-sequence returns every output to its reset value immediately, without waiting for refclk.
- Counters are sized to their parameter (clog2) and never wrap; each saturates at its terminal count.

Test Plan:
Bench parameters: NUM_CH=3, PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, STAGGER=2, MAX_RETRIES=1.
- Clean bring-up: release `rst`, raise pll_locked at cycle 10 and hold.
  - pll_rst high cycles 1-4, low from cycle 5.
  - Sequence WAIT_LOCK -> STABLE; chan_rst[0] clears at entry T, chan_rst[1] at T+2, chan_rst[2] at T+4; all_ready at T+5.
  - retry_cnt=0, lock_lost=0.
- Lock bounce in STABLE: lock high 5 cycles, low 1 cycle, then high.
  - Returns to WAIT_LOCK; release occurs only after 8 further consecutive high cycles; retry_cnt stays 0.
- Timeout and retry: keep lock low.
  - After 20 cycles, retry_cnt=1 and pll_rst pulses 4 cycles.
  - After a second 20-cycle timeout: FAIL, error=1, pll_rst=1, chan_rst=3'b111 held until `rst`.
- Loss in RUN: reach RUN, drop lock for 3 cycles.
  - SYNC_STAGES+1 cycles later: chan_rst=3'b111, all_ready=0, lock_lost=1, pll_rst reasserted for 4 cycles.
  - Re-lock returns to RUN with lock_lost still 1.
- Async reset mid-RELEASE: assert `rst` between refclk edges.
  - All outputs reach reset values before the next edge.
  - Full sequence restarts after `rst` release.
- NUM_PLL=2: lock only one PLL.
  - Never leaves WAIT_LOCK; times out per MAX_RETRIES and ends in FAIL.
